serial_adder_vr: RTL and testbench

Parametrised multi-cycle adder/subtractor that extends the single-bit full adder to WIDTH-bit operands. It processes DIGIT bits per clock using a ripple of full-adder cells, with the carry held in a register between cycles. A start/busy/done handshake lets a controller launch one operation and collect sum, carry-out and signed overflow. It sits between the operand registers and the datapath result bus in the arithmetic lab designs.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/fa_vr.sv | 19 +
 rtl/serial_adder_vr.sv | 142 ++++++++++++++
 tb/tb_serial_adder_vr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   state_t - controller state encoding (IDLE, RUN, DONE)
//   clog2   - ceiling log2, used to size the digit counter
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fa_vr.sv
// fa_vr
// One-bit full adder cell, chained DIGIT times to form the per-cycle ripple.
// Ports:
//   sum   - a ^ b ^ c_in
//   c_out - carry generated or propagated out of this bit
//   a, b  - operand bits
//   c_in  - carry into this bit
module fa_vr (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_vr.sv
// serial_adder_vr
// Multi-cycle WIDTH-bit adder/subtractor that handles DIGIT bits per clock.
// A start/busy/done handshake launches one operation; the result takes
// WIDTH/DIGIT RUN cycles and is presented with a one-cycle done pulse.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - launch request, honoured only in IDLE or DONE
//   sub         - 0: a + b + c_in, 1: a - b (c_in ignored)
//   a, b, c_in  - operands, captured when start is accepted
//   busy        - high while the operation is running
//   done        - one-cycle pulse when sum/c_out/ovf are updated
//   sum         - result, held until the next completed operation
//   c_out       - carry out of the MSB (no-borrow flag when subtracting)
//   ovf         - signed two's-complement overflow
module serial_adder_vr
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  // A single-digit operation still needs a one-bit counter.
  localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_shifted;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [DIGIT-1:0] d_sum;
  logic [DIGIT:0]   chain;

  assign last = (cnt == LAST);

  // Ripple of DIGIT full adders fed by the carry register.
  assign chain[0] = carry;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      fa_vr u_fa (
        .sum  (d_sum[i]),
        .c_out(chain[i+1]),
        .a    (a_sh[i]),
        .b    (b_sh[i]),
        .c_in (chain[i])
      );
    end
  endgenerate

  // New digit enters at the top so that after N cycles the first digit
  // computed has reached bit 0.
  assign sum_shifted = (sum_sh >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Subtraction is a + ~b + 1, so b is inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= sum_shifted;
      carry  <= chain[DIGIT];
      cnt    <= cnt + 1'b1;
    end
  end

  // On the last digit the MSB cell is the top of the ripple, so its carry-in
  // is chain[DIGIT-1] and its carry-out is chain[DIGIT].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if ((state == RUN) && last) begin
      sum   <= sum_shifted;
      c_out <= chain[DIGIT];
      ovf   <= chain[DIGIT] ^ chain[DIGIT-1];
    end
  end

endmodule

// File: tb/tb_serial_adder_vr.sv
// tb_serial_adder_vr
// Drives five serial_adder_vr instances with shared stimulus:
//   0: WIDTH=8 DIGIT=1   1: WIDTH=8 DIGIT=4
//   2: WIDTH=4 DIGIT=1   3: WIDTH=4 DIGIT=2   4: WIDTH=4 DIGIT=4
// Narrow instances see the low bits of the shared operands.
module tb_serial_adder_vr;

  localparam int NINST = 5;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic       c_in;
  logic [7:0] a_drv;
  logic [7:0] b_drv;

  logic       busy_v [NINST];
  logic       done_v [NINST];
  logic [7:0] sum_v  [NINST];
  logic       co_v   [NINST];
  logic       ov_v   [NINST];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: unsigned result/carry and signed range check.
  function automatic void refOp(input int w, input int ua, input int ub, input bit cv,
                                input bit sv, output int res, output bit co, output bit ov);
    int md, half, sa, sb, u, s;
    md   = 1 << w;
    half = 1 << (w - 1);
    sa   = (ua >= half) ? ua - md : ua;
    sb   = (ub >= half) ? ub - md : ub;
    if (sv) begin
      u  = ua - ub;
      s  = sa - sb;
      co = (ua >= ub);
    end else begin
      u  = ua + ub + int'(cv);
      s  = sa + sb + int'(cv);
      co = (u >= md);
    end
    res = ((u % md) + md) % md;
    ov  = (s < -half) || (s > half - 1);
  endfunction

  generate
    for (genvar g = 0; g < NINST; g++) begin : g_dut
      localparam int W = (g < 2) ? 8 : 4;
      localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 1 : (g == 3) ? 2 : 4;
      localparam int N = W / D;

      logic         busy_i, done_i, co_i, ov_i;
      logic [W-1:0] sum_i;

      serial_adder_vr #(.WIDTH(W), .DIGIT(D)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sub  (sub),
        .a    (a_drv[W-1:0]),
        .b    (b_drv[W-1:0]),
        .c_in (c_in),
        .busy (busy_i),
        .done (done_i),
        .sum  (sum_i),
        .c_out(co_i),
        .ovf  (ov_i)
      );

      assign busy_v[g] = busy_i;
      assign done_v[g] = done_i;
      assign sum_v[g]  = 8'(sum_i);
      assign co_v[g]   = co_i;
      assign ov_v[g]   = ov_i;

      // Transaction-level model: an accepted start yields a result N edges later.
      int rem;
      int p_sum, m_sum;
      bit p_co, p_ov, m_co, m_ov, m_busy, m_done;

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem = 0; m_busy = 0; m_done = 0; m_sum = 0; m_co = 0; m_ov = 0;
        end else begin
          m_done = 0;
          if (rem > 0) begin
            rem--;
            if (rem == 0) begin
              m_busy = 0; m_done = 1;
              m_sum = p_sum; m_co = p_co; m_ov = p_ov;
            end
          end else if (start) begin
            refOp(W, int'(a_drv[W-1:0]), int'(b_drv[W-1:0]), c_in, sub, p_sum, p_co, p_ov);
            rem    = N;
            m_busy = 1;
          end
        end
      end

      always @(negedge clk) begin
        checkOutput($sformatf("inst%0d busy", g), int'(busy_i), int'(m_busy));
        checkOutput($sformatf("inst%0d done", g), int'(done_i), int'(m_done));
        checkOutput($sformatf("inst%0d sum", g), int'(sum_i), m_sum);
        checkOutput($sformatf("inst%0d c_out", g), int'(co_i), int'(m_co));
        checkOutput($sformatf("inst%0d ovf", g), int'(ov_i), int'(m_ov));
      end
    end
  endgenerate

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic cv, input logic sv);
    @(negedge clk);
    a_drv = av; b_drv = bv; c_in = cv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Latency counts the start-sampling edge through the edge that raises done.
  task automatic runOp(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv, output int lat0, output int lat1);
    lat0 = -1;
    lat1 = -1;
    applyStimulus(av, bv, cv, sv);
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (done_v[0] && lat0 < 0) lat0 = m + 1;
      if (done_v[1] && lat1 < 0) lat1 = m + 1;
    end
  endtask

  initial begin
    int lat0, lat1, dones, overlap;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; c_in = 1'b0; a_drv = '0; b_drv = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", int'(busy_v[0]), 0);
    checkOutput("reset done", int'(done_v[0]), 0);
    checkOutput("reset sum", int'(sum_v[0]), 0);
    checkOutput("reset c_out", int'(co_v[0]), 0);
    checkOutput("reset ovf", int'(ov_v[0]), 0);
    #2 rst_n = 1'b1;

    runOp(8'h5A, 8'h33, 1'b0, 1'b0, lat0, lat1);
    checkOutput("5A+33 latency d1", lat0, 9);
    checkOutput("5A+33 latency d4", lat1, 3);
    checkOutput("5A+33 sum d1", int'(sum_v[0]), 'h8D);
    checkOutput("5A+33 sum d4", int'(sum_v[1]), 'h8D);
    checkOutput("5A+33 c_out", int'(co_v[0]), 0);
    checkOutput("5A+33 ovf", int'(ov_v[0]), 1);

    runOp(8'hFF, 8'h01, 1'b1, 1'b0, lat0, lat1);
    checkOutput("FF+01+1 sum", int'(sum_v[0]), 'h01);
    checkOutput("FF+01+1 c_out", int'(co_v[0]), 1);
    checkOutput("FF+01+1 ovf", int'(ov_v[0]), 0);

    runOp(8'h10, 8'h20, 1'b0, 1'b1, lat0, lat1);
    checkOutput("10-20 sum", int'(sum_v[0]), 'hF0);
    checkOutput("10-20 c_out", int'(co_v[0]), 0);
    checkOutput("10-20 ovf", int'(ov_v[0]), 0);

    runOp(8'h80, 8'h01, 1'b1, 1'b1, lat0, lat1);
    checkOutput("80-01 sum", int'(sum_v[0]), 'h7F);
    checkOutput("80-01 sum d4", int'(sum_v[1]), 'h7F);
    checkOutput("80-01 c_out", int'(co_v[0]), 1);
    checkOutput("80-01 ovf", int'(ov_v[0]), 1);

    // Start held high: DIGIT=4 instance should finish every 3 cycles.
    @(negedge clk);
    a_drv = 8'h5A; b_drv = 8'h33; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    dones = 0; overlap = 0;
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      if (done_v[1]) dones++;
      if (done_v[1] && busy_v[1]) overlap++;
    end
    start = 1'b0;
    checkOutput("held start done count", dones, 3);
    checkOutput("held start busy&done", overlap, 0);
    repeat (12) @(negedge clk);

    // Second start while busy must not disturb the operation in flight.
    applyStimulus(8'h5A, 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    a_drv = 8'h11; b_drv = 8'h22; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat0 = -1;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (done_v[0] && lat0 < 0) begin
        lat0 = m;
        checkOutput("ignored start sum", int'(sum_v[0]), 'h8D);
      end
    end
    checkOutput("ignored start done seen", int'(lat0 >= 0), 1);
    repeat (4) @(negedge clk);

    // Reset in the middle of RUN abandons the operation.
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("pre-reset busy", int'(busy_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset busy", int'(busy_v[0]), 0);
    checkOutput("mid-run reset done", int'(done_v[0]), 0);
    checkOutput("mid-run reset sum", int'(sum_v[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int m = 0; m < 15; m++) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    checkOutput("no done after reset", dones, 0);

    // Random traffic: starts at random times, operands changing every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a_drv = 8'($urandom);
      b_drv = 8'($urandom);
      c_in  = 1'($urandom);
      sub   = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Every 4-bit operand combination; upper bits random for the 8-bit units.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int sv = 0; sv < 2; sv++) begin
          for (int cv = 0; cv < 2; cv++) begin
            applyStimulus({4'($urandom), 4'(av)}, {4'($urandom), 4'(bv)}, 1'(cv), 1'(sv));
            repeat (10) @(negedge clk);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
